// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Used by uart_rx_frame_ctrl and its testbench.
package uart_frame_pkg;

  // Frame parser states
  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  // Values reported on o_Err_Code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Frame start marker used unless the instance overrides it
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // A length byte is acceptable when it is non-zero and fits in the buffer
  function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Payload output stream of the frame controller: valid/ready handshake
// carrying one signed payload byte with its index and a last flag.
interface uart_rx_frame_ctrl_if #(
  parameter int IDX_W = 4
) ();

  logic                    o_Out_Valid;
  logic                    i_Out_Ready;
  logic signed [7:0]       o_Out_Byte;
  logic [IDX_W-1:0]        o_Out_Index;
  logic                    o_Out_Last;

  modport master (
    output o_Out_Valid,
    output o_Out_Byte,
    output o_Out_Index,
    output o_Out_Last,
    input  i_Out_Ready
  );

  modport slave (
    input  o_Out_Valid,
    input  o_Out_Byte,
    input  o_Out_Index,
    input  o_Out_Last,
    output i_Out_Ready
  );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register array with one synchronous write
// port and one combinational read port. Contents are not reset.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_Clock,
  input  logic             i_Wr_En,
  input  logic [IDX_W-1:0] i_Wr_Addr,
  input  logic [7:0]       i_Wr_Data,
  input  logic [IDX_W-1:0] i_Rd_Addr,
  output logic [7:0]       o_Rd_Data
);

  logic [7:0] r_Mem [DEPTH];

  // Store one payload byte per write strobe
  always_ff @(posedge i_Clock) begin
    if (i_Wr_En) begin
      r_Mem[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  assign o_Rd_Data = r_Mem[i_Rd_Addr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller.
// Hunts for SYNC_BYTE, reads a length byte, buffers the payload, optionally
// verifies an XOR checksum byte, then streams the payload out over a
// valid/ready handshake. Reports bad length, checksum and inter-byte timeout.
// Build option: define UART_FRAME_CHECKSUM_EN to expect and verify the
// trailing checksum byte; without it the frame ends at the last payload byte.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = 1250
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_DV,
  input  logic [7:0]           i_Rx_Byte,
  uart_rx_frame_ctrl_if.master out_if,
  output logic                 o_Frame_Err,
  output logic [1:0]           o_Err_Code,
  output logic                 o_Busy,
  output logic [7:0]           o_Drop_Count
);

  localparam int               IDX_W     = $clog2(MAX_LEN);
  localparam int               CNT_W     = IDX_W + 1;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [23:0]      TMO_LAST  = 24'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_State;
  logic [CNT_W-1:0] r_Len;
  logic [CNT_W-1:0] r_WrIdx;
  logic [IDX_W-1:0] r_RdIdx;
  logic [23:0]      r_Tmo;
  logic             r_OutValid;
  logic             r_OutLast;
  logic             r_FrameErr;
  logic [1:0]       r_ErrCode;
  logic [7:0]       r_DropCount;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]       r_Csum;
`endif

  logic             w_Timed;
  logic             w_TmoHit;
  logic             w_LenOk;
  logic             w_WrEn;
  logic [CNT_W-1:0] w_WrNext;
  logic             w_PayDone;
  logic [CNT_W-1:0] w_RdNext;
  logic             w_Fire;
  logic [7:0]       w_RdData;

  assign w_Timed   = (r_State == S_LEN) || (r_State == S_PAYLOAD) || (r_State == S_CHECK);
  assign w_TmoHit  = w_Timed && (r_Tmo == TMO_LAST);
  assign w_LenOk   = len_ok(i_Rx_Byte, MAX_LEN_B);
  assign w_WrEn    = (r_State == S_PAYLOAD) && i_Rx_DV;
  assign w_WrNext  = r_WrIdx + CNT_ONE;
  assign w_PayDone = (w_WrNext == r_Len);
  assign w_RdNext  = {1'b0, r_RdIdx} + CNT_ONE;
  assign w_Fire    = r_OutValid && out_if.i_Out_Ready;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .IDX_W (IDX_W)
  ) u_buf (
    .i_Clock   (i_Clock),
    .i_Wr_En   (w_WrEn),
    .i_Wr_Addr (r_WrIdx[IDX_W-1:0]),
    .i_Wr_Data (i_Rx_Byte),
    .i_Rd_Addr (r_RdIdx),
    .o_Rd_Data (w_RdData)
  );

  // Frame sequencer: parsing, timeout supervision, drain handshake and error reporting
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State     <= S_SYNC;
      r_Len       <= '0;
      r_WrIdx     <= '0;
      r_RdIdx     <= '0;
      r_Tmo       <= '0;
      r_OutValid  <= 1'b0;
      r_OutLast   <= 1'b0;
      r_FrameErr  <= 1'b0;
      r_ErrCode   <= ERR_NONE;
      r_DropCount <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      r_Csum      <= '0;
`endif
    end else begin
      r_FrameErr <= 1'b0;

      if (!w_Timed || i_Rx_DV) begin
        r_Tmo <= '0;
      end else if (!w_TmoHit) begin
        r_Tmo <= r_Tmo + 24'd1;
      end

      case (r_State)
        S_SYNC: begin
          if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
            r_State <= S_LEN;
          end
        end

        S_LEN: begin
          if (i_Rx_DV) begin
            if (!w_LenOk) begin
              r_FrameErr <= 1'b1;
              r_ErrCode  <= ERR_LEN;
              r_State    <= S_SYNC;
            end else begin
              r_Len   <= i_Rx_Byte[CNT_W-1:0];
              r_WrIdx <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
              r_Csum  <= i_Rx_Byte;
`endif
              r_State <= S_PAYLOAD;
            end
          end else if (w_TmoHit) begin
            r_FrameErr <= 1'b1;
            r_ErrCode  <= ERR_TIMEOUT;
            r_State    <= S_SYNC;
          end
        end

        S_PAYLOAD: begin
          if (i_Rx_DV) begin
            r_WrIdx <= w_WrNext;
`ifdef UART_FRAME_CHECKSUM_EN
            r_Csum  <= r_Csum ^ i_Rx_Byte;
            if (w_PayDone) begin
              r_State <= S_CHECK;
            end
`else
            if (w_PayDone) begin
              r_State    <= S_DRAIN;
              r_RdIdx    <= '0;
              r_OutValid <= 1'b1;
              r_OutLast  <= (r_Len == CNT_ONE);
            end
`endif
          end else if (w_TmoHit) begin
            r_FrameErr <= 1'b1;
            r_ErrCode  <= ERR_TIMEOUT;
            r_State    <= S_SYNC;
          end
        end

`ifdef UART_FRAME_CHECKSUM_EN
        S_CHECK: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte == r_Csum) begin
              r_State    <= S_DRAIN;
              r_RdIdx    <= '0;
              r_OutValid <= 1'b1;
              r_OutLast  <= (r_Len == CNT_ONE);
            end else begin
              r_FrameErr <= 1'b1;
              r_ErrCode  <= ERR_CSUM;
              r_State    <= S_SYNC;
            end
          end else if (w_TmoHit) begin
            r_FrameErr <= 1'b1;
            r_ErrCode  <= ERR_TIMEOUT;
            r_State    <= S_SYNC;
          end
        end
`endif

        S_DRAIN: begin
          if (i_Rx_DV && (r_DropCount != 8'hFF)) begin
            r_DropCount <= r_DropCount + 8'd1;
          end
          if (w_Fire) begin
            if (r_OutLast) begin
              r_OutValid <= 1'b0;
              r_OutLast  <= 1'b0;
              r_RdIdx    <= '0;
              r_State    <= S_SYNC;
            end else begin
              r_RdIdx   <= w_RdNext[IDX_W-1:0];
              r_OutLast <= (w_RdNext == (r_Len - CNT_ONE));
            end
          end
        end

        default: begin
          r_State <= S_SYNC;
        end
      endcase
    end
  end

  assign out_if.o_Out_Valid = r_OutValid;
  assign out_if.o_Out_Byte  = r_OutValid ? $signed(w_RdData) : 8'sd0;
  assign out_if.o_Out_Index = r_RdIdx;
  assign out_if.o_Out_Last  = r_OutLast;
  assign o_Frame_Err        = r_FrameErr;
  assign o_Err_Code         = r_ErrCode;
  assign o_Busy             = (r_State != S_SYNC);
  assign o_Drop_Count       = r_DropCount;

endmodule
